// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package adder_arbiter_pkg;

   // Default operand/sum width
   localparam int W_DEFAULT = 16;

   // Widest requester vector the search helper handles
   localparam int MAX_REQ = 16;

   // IDLE: no result held; HOLD: a result is presented on the response channel
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Rotating-priority search: first set bit of req, scanning upward from ptr
   // and wrapping within the n active lanes. Returns -1 when no bit is set.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                  input int                 ptr,
                                  input int                 n);
      int pick;
      int idx;
      pick = -1;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (ptr + k) % n;
         if ((k < n) && (pick < 0) && (|(req & (MAX_REQ'(1) << idx)))) begin
            pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant selection: one-hot grant plus binary index, starting at ptr.
// Latency: purely combinational.
// Backpressure: enable=0 forces an all-zero grant; the pointer register lives in the parent.
module rr_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   logic [MAX_REQ-1:0] req_ext;
   int                 pick;

   // Search from the pointer and convert the winner into grant/index form
   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
      pick                = rr_pick(req_ext, int'(ptr), NREQ);
      grant               = '0;
      idx                 = '0;
      if (enable && (pick >= 0)) begin
         idx   = IDW'(pick);
         grant = NREQ'(1) << pick;
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered W-bit adder among NREQ requesters with round-robin grants.
// Latency: one cycle from the accept edge to rsp_valid; one result per cycle at full rate.
// Backpressure: rsp_ready=0 freezes the held result and blocks all grants until released.
// Build option: define ADDER_ARBITER_SAT_EN for a saturating add (carry becomes the saturation flag).
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int W    = W_DEFAULT,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic [W-1:0]    rsp_sum,
   output logic            rsp_carry,
   output logic            busy
);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic           can_accept;
   logic           accept;
   logic [W-1:0]   a_win;
   logic [W-1:0]   b_win;
   logic [W:0]     sum_full;
   logic [W-1:0]   res_sum;
   logic           res_carry;

   // A new operand pair can be taken when nothing is held or the held result leaves this cycle
   assign can_accept = !rst && ((state == IDLE) || ((state == HOLD) && rsp_ready));

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (ptr),
      .enable (can_accept),
      .grant  (req_ready),
      .idx    (win)
   );

   assign accept = |req_ready;

   // Winner's operands through the shared adder, one extra bit for the carry
   assign a_win    = req_a[int'(win)*W +: W];
   assign b_win    = req_b[int'(win)*W +: W];
   assign sum_full = {1'b0, a_win} + {1'b0, b_win};

`ifdef ADDER_ARBITER_SAT_EN
   assign res_sum = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
   assign res_sum = sum_full[W-1:0];
`endif
   assign res_carry = sum_full[W];

   assign rsp_valid = (state == HOLD);
   assign busy      = rsp_valid || (|req_valid);

   // Next state: enter/stay in HOLD on accept, drop to IDLE once the result is taken with no replacement
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = HOLD;
         HOLD: if (rsp_ready && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, rotating pointer and response registers; the response only changes on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ptr       <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
            rsp_id    <= win;
            rsp_sum   <= res_sum;
            rsp_carry <= res_carry;
         end
      end
   end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered 16-bit adder (C = A + B) among NREQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake.
- Each result returns on a single response channel tagged with the winner's ID. The channel supports backpressure.
- Sits between test-bench/CPU-side operand producers and the shared adder datapath. It sequences all adder use.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- W, 16, operand and sum width.
- IDW, $clog2(NREQ), width of requester ID (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high per cycle
- req_a  in  NREQ*W  packed A operands; requester i occupies bits [i*W +: W]
- req_b  in  NREQ*W  packed B operands, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that produced the result
- rsp_sum  out  W  result sum
- rsp_carry  out  1  carry-out of the W-bit add
- busy  out  1  high whenever rsp_valid is high or any req_valid is high

Behaviour:
- Reset values (synchronous, takes priority over all other actions): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rr pointer=0, state=IDLE.
- req_ready is combinational. It is forced to 0 while rst=1.
- Accept condition: can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
  - When can_accept=1 and any req_valid is high, exactly one req_ready bit is asserted, for the winner.
  - Otherwise all req_ready bits are 0.
- Arbitration:
  - Round-robin starting at the rr pointer, searching upward with wrap: pointer, pointer+1, ..., NREQ-1, 0, ...
  - On each accept, the pointer becomes (winner+1) mod NREQ.
  - The pointer is unchanged when nothing is accepted.
- Datapath:
  - On the accept edge: {rsp_carry, rsp_sum} <= req_a[win] + req_b[win], computed at W+1 bits; rsp_id <= win; rsp_valid <= 1.
- Latency: one cycle from the accept edge to rsp_valid=1.
- Throughput: one result per cycle when rsp_ready is held at 1, with back-to-back grants.
- FSM:
  - IDLE -> HOLD on accept.
  - HOLD -> HOLD when rsp_ready=1 and a new accept occurs in the same cycle (result replaced).
  - HOLD -> IDLE when rsp_ready=1 and there is no new request.
  - HOLD stays HOLD with outputs frozen while rsp_ready=0.
- Response stability: rsp_id, rsp_sum and rsp_carry remain stable while rsp_valid=1 & rsp_ready=0.
- Requester rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - A requester that drops req_valid before its grant is skipped, with no error.
- Wrap-around:
  - A sum overflow wraps modulo 2^W, with rsp_carry=1. Example: 0xFFFF+0x0001 gives sum 0x0000, carry 1.
  - Pointer wrap from NREQ-1 goes to 0.
- Reset mid-operation: a pending HOLD result is discarded and rsp_valid drops on the next edge. No req_ready is asserted during reset.

Optional Feature:
- Macro: ADDER_ARBITER_SAT_EN.
- Defined: saturating add. When the W-bit add overflows, rsp_sum = {W{1'b1}} and rsp_carry = 1 (carry acts as a saturation flag).
- Undefined: wrapping add as described in Behaviour. Ports and timing are identical in both builds.

Decomposition:
- Package adder_arbiter_pkg holds:
  - localparam default W=16
  - the state typedef enum {IDLE, HOLD}
  - a function for the rotating-priority search
- One sub-module rr_arbiter (NREQ):
  - inputs: req vector, pointer, enable
  - outputs: one-hot grant and binary index
  - purely combinational
  - its pointer register lives in adder_arbiter

Test Plan:
1. Reset then single request: rst high 2 cycles; req_valid=4'b0001, A0=10, B0=20 -> req_ready[0] in first cycle after reset, next cycle rsp_valid=1, rsp_id=0, rsp_sum=30, rsp_carry=0.
2. All four requesting continuously with rsp_ready=1: A_i=100*i, B_i=300 -> grant order 0,1,2,3,0,...; rsp_sum 300,400,500,600; one result per cycle.
3. Backpressure: rsp_ready=0 for 5 cycles after a result with A=1, B=0 -> rsp_sum=1 and rsp_id frozen, all req_ready=0; rsp_ready=1 releases it and the next grant occurs in that same cycle.
4. Overflow: A=0xFFFF, B=0x0001 -> rsp_sum=0x0000, rsp_carry=1. With ADDER_ARBITER_SAT_EN: rsp_sum=0xFFFF, rsp_carry=1. A=0x8000, B=0x7FFF -> 0xFFFF, carry 0 in both builds.
5. Fairness/wrap: pointer at 3; requests from 1 and 3 -> grant 3, then 1; requester 2 drops req_valid before its grant and is skipped.
6. Reset mid-operation: rst asserted while in HOLD with rsp_sum=0x0042 -> next edge rsp_valid=0, rsp_sum=0, pointer=0; first grant after reset goes to the lowest-index active requester.
